// File: rtl/tm_inference_sequencer_if.sv
// Stream-side bundle of the inference sequencer: input beat handshake and result output stream.
// slave is the sequencer's view; master is the view of the host driving beats and taking results.
interface tm_inference_sequencer_if #(
  parameter int unsigned DATA_W = 64
);
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic              s_axis_tlast;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic [DATA_W/8-1:0] m_axis_tkeep;
  logic              m_axis_tlast;

  modport slave (
    input  s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
  );

  modport master (
    output s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
  );
endinterface

// File: rtl/tm_inference_sequencer.sv
// Control-path sequencer for the Tsetlin inference pipeline: frames input beats into datapoints,
// meters datapoints with credits, and returns datapath results in order on the output stream.
module tm_inference_sequencer #(
  parameter int unsigned PACKETS                = 13,
  parameter int unsigned RES_DEPTH              = 4,
  parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  tm_inference_sequencer_if.slave           axis,
  output logic                              dp_load,
  output logic [$clog2(PACKETS)-1:0]        dp_packet_idx,
  output logic                              dp_end,
  output logic                              dp_abort,
  input  logic                              dp_result_valid,
  input  logic [C_M00_AXIS_TDATA_WIDTH-1:0] dp_result,
  output logic [$clog2(RES_DEPTH+1)-1:0]    inflight,
  output logic                              err_short_frame,
  output logic                              err_unexpected
);

  localparam int unsigned IW = $clog2(PACKETS);
  localparam int unsigned CW = $clog2(RES_DEPTH + 1);
  localparam int unsigned PW = $clog2(RES_DEPTH);
  localparam int unsigned DW = C_M00_AXIS_TDATA_WIDTH;
  localparam int unsigned KW = DW / 8;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_e;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } res_t;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   credits_q, credits_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   res_cnt_q, res_cnt_d;
  logic [PW-1:0]   tag_wr_q, tag_wr_d;
  logic [PW-1:0]   tag_rd_q, tag_rd_d;
  logic [PW-1:0]   res_wr_q, res_wr_d;
  logic [PW-1:0]   res_rd_q, res_rd_d;
  logic [RES_DEPTH-1:0] tag_mem_q, tag_mem_d;
  res_t            res_mem_q [RES_DEPTH];
  res_t            res_mem_d [RES_DEPTH];
  logic            err_short_q, err_short_d;
  logic            err_unexp_q, err_unexp_d;

  logic            s_ready_c;
  logic            load_c;
  logic            last_pkt_c;
  logic            launch_c;
  logic            abort_c;
  logic            take_c;
  logic            res_acc_c;
  logic            m_valid_c;
  logic            pop_c;
  res_t            head_c;

  // Handshake decode from registered state; ready is held low while reset is asserted.
  always_comb begin
    s_ready_c  = !rst && ((state_q == LOAD) || (credits_q != '0));
    load_c     = axis.s_axis_tvalid && s_ready_c;
    last_pkt_c = (idx_q == IW'(PACKETS - 1));
    launch_c   = load_c && last_pkt_c;
    abort_c    = load_c && axis.s_axis_tlast && !last_pkt_c;
    take_c     = load_c && (state_q == IDLE);
    res_acc_c  = dp_result_valid && (inflight_q != '0);
    m_valid_c  = !rst && (res_cnt_q != '0);
    pop_c      = m_valid_c && axis.m_axis_tready;
    head_c     = res_mem_q[res_rd_q];
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tag_wr_d    = tag_wr_q;
    tag_rd_d    = tag_rd_q;
    res_wr_d    = res_wr_q;
    res_rd_d    = res_rd_q;
    tag_mem_d   = tag_mem_q;
    res_mem_d   = res_mem_q;

    if (load_c) begin
      if (launch_c || abort_c) begin
        state_d = IDLE;
        idx_d   = '0;
      end else begin
        state_d = LOAD;
        idx_d   = idx_q + IW'(1);
      end
    end

    // An abort in IDLE cancels its own credit take; an abort in LOAD hands the held credit back.
    credits_d  = credits_q + CW'(pop_c) + CW'(abort_c) - CW'(take_c);
    inflight_d = inflight_q + CW'(launch_c) - CW'(res_acc_c);
    res_cnt_d  = res_cnt_q + CW'(res_acc_c) - CW'(pop_c);

    if (launch_c) begin
      tag_mem_d[tag_wr_q] = axis.s_axis_tlast;
      tag_wr_d            = tag_wr_q + PW'(1);
    end

    if (res_acc_c) begin
      res_mem_d[res_wr_q].last = tag_mem_q[tag_rd_q];
      res_mem_d[res_wr_q].data = dp_result;
      tag_rd_d                 = tag_rd_q + PW'(1);
      res_wr_d                 = res_wr_q + PW'(1);
    end

    if (pop_c) begin
      res_rd_d = res_rd_q + PW'(1);
    end

    err_short_d = err_short_q | abort_c;
    err_unexp_d = err_unexp_q | (dp_result_valid && (inflight_q == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      credits_q   <= CW'(RES_DEPTH);
      inflight_q  <= '0;
      res_cnt_q   <= '0;
      tag_wr_q    <= '0;
      tag_rd_q    <= '0;
      res_wr_q    <= '0;
      res_rd_q    <= '0;
      tag_mem_q   <= '0;
      err_short_q <= 1'b0;
      err_unexp_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      credits_q   <= credits_d;
      inflight_q  <= inflight_d;
      res_cnt_q   <= res_cnt_d;
      tag_wr_q    <= tag_wr_d;
      tag_rd_q    <= tag_rd_d;
      res_wr_q    <= res_wr_d;
      res_rd_q    <= res_rd_d;
      tag_mem_q   <= tag_mem_d;
      err_short_q <= err_short_d;
      err_unexp_q <= err_unexp_d;
    end
  end

  // Result storage needs no reset: occupancy is tracked by res_cnt_q and outputs are gated by it.
  always_ff @(posedge clk) begin
    res_mem_q <= res_mem_d;
  end

  assign axis.s_axis_tready = s_ready_c;
  assign axis.m_axis_tvalid = m_valid_c;
  assign axis.m_axis_tdata  = m_valid_c ? head_c.data : '0;
  assign axis.m_axis_tkeep  = {KW{m_valid_c}};
  assign axis.m_axis_tlast  = m_valid_c & head_c.last;

  assign dp_load         = load_c;
  assign dp_packet_idx   = idx_q;
  assign dp_end          = launch_c;
  assign dp_abort        = abort_c;
  assign inflight        = inflight_q;
  assign err_short_frame = err_short_q;
  assign err_unexpected  = err_unexp_q;

endmodule

// File: tb/tb_tm_inference_sequencer.sv
// Randomized bench for tm_inference_sequencer: a queue-based model of datapoints, credits and
// buffered results predicts every cycle; a negedge monitor compares and scores the DUT.
module tb_tm_inference_sequencer;

  localparam int unsigned PACKETS   = 13;
  localparam int unsigned RES_DEPTH = 4;
  localparam int unsigned W         = 64;
  localparam int unsigned IW        = $clog2(PACKETS);
  localparam int unsigned CW        = $clog2(RES_DEPTH + 1);

  typedef struct packed {
    logic         last;
    logic [W-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          dp_load, dp_end, dp_abort;
  logic [IW-1:0] dp_packet_idx;
  logic          dp_result_valid;
  logic [W-1:0]  dp_result;
  logic [CW-1:0] inflight;
  logic          err_short_frame, err_unexpected;

  always #5 clk = ~clk;

  tm_inference_sequencer_if #(.DATA_W(W)) axis ();

  tm_inference_sequencer #(
    .PACKETS               (PACKETS),
    .RES_DEPTH             (RES_DEPTH),
    .C_M00_AXIS_TDATA_WIDTH(W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .axis           (axis),
    .dp_load        (dp_load),
    .dp_packet_idx  (dp_packet_idx),
    .dp_end         (dp_end),
    .dp_abort       (dp_abort),
    .dp_result_valid(dp_result_valid),
    .dp_result      (dp_result),
    .inflight       (inflight),
    .err_short_frame(err_short_frame),
    .err_unexpected (err_unexpected)
  );

  // Reference model: beats of the open datapoint, tags of launched datapoints, expected outputs.
  int   beat_cnt;
  bit   launched_q[$];
  exp_t exp_q[$];
  bit   m_err_short, m_err_unexp;
  int   checks, errors;

  int unsigned s_valid_pct, m_ready_pct, r_pct, short_pct;
  bit          force_unexp;

  bit   exp_ready, s_hs, last_beat, m_hs, tag;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare against the model, then advance the model by this cycle's handshakes.
  always @(negedge clk) begin
    if (rst) begin
      chk("s_tready_in_rst", 64'(axis.s_axis_tready), 64'd0);
      beat_cnt    = 0;
      launched_q.delete();
      exp_q.delete();
      m_err_short = 1'b0;
      m_err_unexp = 1'b0;
    end else begin
      // Free credits = depth minus open, launched and buffered datapoints.
      exp_ready = (beat_cnt > 0) || (launched_q.size() + exp_q.size() < RES_DEPTH);
      s_hs      = axis.s_axis_tvalid && exp_ready;
      last_beat = (beat_cnt == PACKETS - 1);
      chk("s_tready", 64'(axis.s_axis_tready), 64'(exp_ready));
      chk("dp_load", 64'(dp_load), 64'(s_hs));
      chk("dp_packet_idx", 64'(dp_packet_idx), 64'(beat_cnt));
      chk("dp_end", 64'(dp_end), 64'(s_hs && last_beat));
      chk("dp_abort", 64'(dp_abort), 64'(s_hs && axis.s_axis_tlast && !last_beat));
      chk("inflight", 64'(inflight), 64'(launched_q.size()));
      chk("err_short_frame", 64'(err_short_frame), 64'(m_err_short));
      chk("err_unexpected", 64'(err_unexpected), 64'(m_err_unexp));
      chk("m_tvalid", 64'(axis.m_axis_tvalid), 64'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        chk("m_tdata", axis.m_axis_tdata, exp_q[0].data);
        chk("m_tlast", 64'(axis.m_axis_tlast), 64'(exp_q[0].last));
        chk("m_tkeep", 64'(axis.m_axis_tkeep), 64'hFF);
      end else begin
        chk("m_tkeep_idle", 64'(axis.m_axis_tkeep), 64'd0);
      end

      m_hs = (exp_q.size() > 0) && axis.m_axis_tready;
      if (m_hs) void'(exp_q.pop_front());
      if (dp_result_valid) begin
        if (launched_q.size() > 0) begin
          tag = launched_q.pop_front();
          exp_q.push_back(exp_t'{last: tag, data: dp_result});
        end else begin
          m_err_unexp = 1'b1;
        end
      end
      if (s_hs) begin
        if (last_beat) begin
          launched_q.push_back(axis.s_axis_tlast);
          beat_cnt = 0;
        end else if (axis.s_axis_tlast) begin
          m_err_short = 1'b1;
          beat_cnt    = 0;
        end else begin
          beat_cnt++;
        end
      end
    end
  end

  // One clock of randomized stimulus, applied just after the active edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    axis.s_axis_tvalid = ($urandom_range(99) < s_valid_pct);
    if (beat_cnt == PACKETS - 1) axis.s_axis_tlast = 1'($urandom_range(1));
    else                         axis.s_axis_tlast = ($urandom_range(99) < short_pct);
    axis.m_axis_tready = ($urandom_range(99) < m_ready_pct);
    dp_result_valid    = force_unexp || ((launched_q.size() > 0) && ($urandom_range(99) < r_pct));
    dp_result          = {$urandom, $urandom};
  endtask

  task automatic drain();
    int n = 0;
    s_valid_pct = 0;
    m_ready_pct = 100;
    r_pct       = 100;
    while ((launched_q.size() > 0 || exp_q.size() > 0) && n < 300) begin
      cycle();
      n++;
    end
    chk("drain_bound", 64'(n < 300), 64'd1);
  endtask

  task automatic phase(input int unsigned sv, input int unsigned mr, input int unsigned rp,
                       input int unsigned sp, input int ncyc);
    s_valid_pct = sv;
    m_ready_pct = mr;
    r_pct       = rp;
    short_pct   = sp;
    repeat (ncyc) cycle();
  endtask

  initial begin
    int n;
    checks             = 0;
    errors             = 0;
    rst                = 1'b1;
    force_unexp        = 1'b0;
    axis.s_axis_tvalid = 1'b0;
    axis.s_axis_tlast  = 1'b0;
    axis.m_axis_tready = 1'b0;
    dp_result_valid    = 1'b0;
    dp_result          = '0;
    s_valid_pct = 0; m_ready_pct = 0; r_pct = 0; short_pct = 0;
    repeat (3) cycle();
    rst = 1'b0;
    repeat (2) cycle();

    // Result strobe with nothing launched: sticky error, output stays idle.
    force_unexp = 1'b1;
    cycle();
    force_unexp = 1'b0;
    repeat (4) cycle();

    // Clean full-rate traffic, then traffic with frequent short frames.
    phase(100, 100, 60, 0, 300);
    phase(70, 70, 50, 12, 400);
    drain();

    // Output stalled: four datapoints fill the credits, then release and refill.
    phase(100, 0, 100, 0, 150);
    phase(100, 100, 100, 0, 80);
    drain();

    // Reset while mid-datapoint at beat 7 with two results buffered.
    s_valid_pct = 100; m_ready_pct = 0; r_pct = 100; short_pct = 0;
    n = 0;
    while (!(exp_q.size() >= 2 && beat_cnt == 7) && n < 400) begin
      cycle();
      n++;
    end
    chk("mid_load_setup", 64'(n < 400), 64'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    s_valid_pct = 0;
    repeat (3) cycle();

    // Long mixed run with random back-pressure on both sides.
    phase(60, 50, 40, 5, 2000);
    phase(90, 90, 80, 2, 500);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
